lock_ctrl_multi: RTL and testbench

Parametrised next-generation door-lock controller. Owns PIN entry, multi-slot PIN matching, escalating failure lockout, auto-relock and door-open alarm. It takes keypad events and door/button inputs and drives the latch, buzzer and display. Slot 0 is the master PIN, which hands control to the setup block via a req/done handshake.

---
 rtl/lock_pkg.sv | 37 +++
 rtl/pin_match.sv | 26 ++
 rtl/lock_ctrl_multi.sv | 220 ++++++++++++++++++++++
 tb/tb_lock_ctrl_multi.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types, key/display codes and the lockout-duration helper for the door-lock controller.
package lock_pkg;

    typedef enum logic [3:0] {
        StPowerup,
        StLocked,
        StEntry,
        StCheck,
        StFailWait,
        StUnlock,
        StOpen,
        StClosed,
        StSetup
    } lock_state_t;

    localparam logic [3:0] KEY_CLR    = 4'hE;
    localparam logic [3:0] DISP_BLANK = 4'hA;
    localparam logic [3:0] DISP_FAIL  = 4'hB;

    // Lockout length in seconds for an already-incremented failure count.
    function automatic int unsigned wait_secs(input logic [3:0] fail_cnt,
                                              input int unsigned free_tries,
                                              input int unsigned step_s,
                                              input int unsigned max_wait_s);
        int unsigned fc;
        int unsigned w;
        fc = {28'd0, fail_cnt};
        if (fc <= free_tries) begin
            w = 1;
        end else begin
            w = step_s * (fc - free_tries);
            if (w > max_wait_s) w = max_wait_s;
        end
        return w;
    endfunction

endpackage

// File: rtl/pin_match.sv
// Parallel comparison of the entered PIN against every slot; slot 0 (master) is always enabled.
module pin_match #(
    parameter int unsigned NUM_PINS   = 4,
    parameter int unsigned PIN_DIGITS = 4
) (
    input  logic [PIN_DIGITS*4-1:0]          entry,
    input  logic [NUM_PINS*PIN_DIGITS*4-1:0] pin_table,
    input  logic [NUM_PINS-1:0]              pin_en,
    output logic                             match_any,
    output logic                             match_master
);

    localparam int unsigned W = PIN_DIGITS * 4;

    logic unused_en0;
    assign unused_en0 = pin_en[0];

    always_comb begin
        match_master = (pin_table[W-1:0] == entry);
        match_any    = match_master;
        for (int unsigned k = 1; k < NUM_PINS; k++) begin
            if (pin_en[k] && (pin_table[k*W +: W] == entry)) match_any = 1'b1;
        end
    end

endmodule

// File: rtl/lock_ctrl_multi.sv
// Door-lock controller: PIN entry, multi-slot match, escalating lockout, auto-relock, door alarm.
module lock_ctrl_multi
    import lock_pkg::*;
#(
    parameter int unsigned NUM_PINS        = 4,
    parameter int unsigned PIN_DIGITS      = 4,
    parameter int unsigned TICK_DIV        = 1000,
    parameter int unsigned FREE_TRIES      = 3,
    parameter int unsigned STEP_S          = 10,
    parameter int unsigned MAX_WAIT_S      = 60,
    parameter int unsigned ENTRY_TIMEOUT_S = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             door_open,
    input  logic                             inside_btn,
    input  logic [NUM_PINS*PIN_DIGITS*4-1:0] pin_table,
    input  logic [NUM_PINS-1:0]              pin_en,
    input  logic                             cfg_bip_en,
    input  logic [6:0]                       cfg_bip_s,
    input  logic [6:0]                       cfg_lock_s,
    output logic                             setup_req,
    input  logic                             setup_done,
    output logic                             latch,
    output logic                             buzzer,
    output logic                             disp_en,
    output logic [PIN_DIGITS*4-1:0]          disp,
    output logic [3:0]                       fail_cnt,
    output logic                             locked_out
);

    localparam int unsigned W     = PIN_DIGITS * 4;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    lock_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [W-1:0]     buf_q, buf_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       idle_q, idle_d;
    logic [6:0]       wait_q, wait_d;
    logic [6:0]       open_q, open_d;
    logic [6:0]       closed_q, closed_d;
    logic [3:0]       fail_d;
    logic             btn_q;
    logic             latch_d, buzzer_d, disp_en_d, setup_req_d, locked_out_d;
    logic [W-1:0]     disp_d;
    logic             tick, btn_rise, key_ok, key_digit, key_clr;
    logic             match_any, match_master;

    assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
    assign btn_rise  = inside_btn & ~btn_q;
    assign key_ok    = key_valid & ~door_open & ((state_q == StLocked) | (state_q == StEntry));
    assign key_digit = key_ok & (key_code <= 4'd9);
    assign key_clr   = key_ok & (key_code == KEY_CLR);

    pin_match #(
        .NUM_PINS   (NUM_PINS),
        .PIN_DIGITS (PIN_DIGITS)
    ) u_pin_match (
        .entry        (buf_q),
        .pin_table    (pin_table),
        .pin_en       (pin_en),
        .match_any    (match_any),
        .match_master (match_master)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        wait_d   = wait_q;
        open_d   = open_q;
        closed_d = closed_q;
        fail_d   = fail_cnt;
        case (state_q)
            StPowerup: if (!door_open) state_d = StLocked;
            StLocked: begin
                if (key_digit) begin
                    buf_d   = {{(W-4){1'b0}}, key_code};
                    cnt_d   = 4'd1;
                    idle_d  = '0;
                    state_d = StEntry;
                end else if (btn_rise) begin
                    state_d = StUnlock;
                end
            end
            StEntry: begin
                if (32'(cnt_q) == PIN_DIGITS) begin
                    state_d = StCheck;
                end else if (key_clr) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StLocked;
                end else if (key_digit) begin
                    buf_d  = {buf_q[W-5:0], key_code};
                    cnt_d  = cnt_q + 4'd1;
                    idle_d = '0;
                end else if (tick) begin
                    if (32'(idle_q) + 32'd1 >= ENTRY_TIMEOUT_S) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = StLocked;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            StCheck: begin
                buf_d = '0;
                cnt_d = '0;
                if (match_master) begin
                    fail_d  = '0;
                    state_d = StSetup;
                end else if (match_any) begin
                    fail_d  = '0;
                    state_d = StUnlock;
                end else begin
                    fail_d  = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;
                    wait_d  = '0;
                    state_d = StFailWait;
                end
            end
            StFailWait: begin
                // The count of elapsed ticks includes the first, partial one.
                if (tick) begin
                    if (32'(wait_q) + 32'd1 >= wait_secs(fail_cnt, FREE_TRIES, STEP_S, MAX_WAIT_S))
                        state_d = StLocked;
                    else
                        wait_d = wait_q + 7'd1;
                end
            end
            StUnlock: begin
                open_d   = '0;
                closed_d = '0;
                state_d  = StOpen;
            end
            StOpen: begin
                if (!door_open) begin
                    open_d   = '0;
                    closed_d = '0;
                    state_d  = StClosed;
                end else if (tick && (open_q < cfg_bip_s)) begin
                    open_d = open_q + 7'd1;
                end
            end
            StClosed: begin
                if (door_open) begin
                    open_d   = '0;
                    closed_d = '0;
                    state_d  = StOpen;
                end else if (btn_rise || (closed_q >= cfg_lock_s)) begin
                    state_d = StLocked;
                end else if (tick && (closed_q != 7'h7F)) begin
                    closed_d = closed_q + 7'd1;
                end
            end
            StSetup: if (setup_done) state_d = StLocked;
            default: state_d = StPowerup;
        endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        latch_d      = state_d inside {StPowerup, StUnlock, StOpen, StClosed};
        buzzer_d     = (state_d == StOpen) & cfg_bip_en & (open_d >= cfg_bip_s);
        disp_en_d    = state_d inside {StLocked, StEntry, StCheck, StFailWait};
        setup_req_d  = (state_d == StSetup);
        locked_out_d = (state_d == StFailWait);
        disp_d       = {PIN_DIGITS{DISP_BLANK}};
        if (state_d == StFailWait) begin
            disp_d = {PIN_DIGITS{DISP_FAIL}};
        end else if ((state_d == StEntry) || (state_d == StCheck)) begin
            for (int unsigned i = 0; i < PIN_DIGITS; i++) begin
                if (i < 32'(cnt_d)) disp_d[i*4 +: 4] = buf_d[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            state_q    <= StPowerup;
            buf_q      <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            wait_q     <= '0;
            open_q     <= '0;
            closed_q   <= '0;
            fail_cnt   <= '0;
            btn_q      <= 1'b0;
            latch      <= 1'b1;
            buzzer     <= 1'b0;
            disp_en    <= 1'b0;
            disp       <= {PIN_DIGITS{DISP_BLANK}};
            setup_req  <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            div_q      <= tick ? '0 : div_q + 1'b1;
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            wait_q     <= wait_d;
            open_q     <= open_d;
            closed_q   <= closed_d;
            fail_cnt   <= fail_d;
            btn_q      <= inside_btn;
            latch      <= latch_d;
            buzzer     <= buzzer_d;
            disp_en    <= disp_en_d;
            disp       <= disp_d;
            setup_req  <= setup_req_d;
            locked_out <= locked_out_d;
        end
    end

endmodule

// File: tb/tb_lock_ctrl_multi.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor checks each change it sees.
module tb_lock_ctrl_multi;

    localparam int BIG = 100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid, door_open, inside_btn, setup_done;
    logic [3:0]  key_code;
    logic [63:0] pin_table;
    logic [3:0]  pin_en;
    logic        cfg_bip_en;
    logic [6:0]  cfg_bip_s, cfg_lock_s;
    logic        setup_req, latch, buzzer, disp_en, locked_out;
    logic [15:0] disp;
    logic [3:0]  fail_cnt;

    logic [15:0] slot_pin [4] = '{16'h1234, 16'h0000, 16'h5678, 16'h4321};
    logic [3:0]  slot_en = 4'b0010;

    lock_ctrl_multi #(
        .NUM_PINS        (4),
        .PIN_DIGITS      (4),
        .TICK_DIV        (10),
        .FREE_TRIES      (3),
        .STEP_S          (10),
        .MAX_WAIT_S      (60),
        .ENTRY_TIMEOUT_S (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .door_open  (door_open),
        .inside_btn (inside_btn),
        .pin_table  (pin_table),
        .pin_en     (pin_en),
        .cfg_bip_en (cfg_bip_en),
        .cfg_bip_s  (cfg_bip_s),
        .cfg_lock_s (cfg_lock_s),
        .setup_req  (setup_req),
        .setup_done (setup_done),
        .latch      (latch),
        .buzzer     (buzzer),
        .disp_en    (disp_en),
        .disp       (disp),
        .fail_cnt   (fail_cnt),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] val;
        int          min_gap;
        int          max_gap;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic [23:0] mon_last;
    int          gap = 0;
    logic [3:0]  m_fc = 4'd0;
    logic [3:0]  m_digits[$];

    // Observable tuple: a disabled display is treated as blank.
    wire [23:0] cur = {latch, buzzer, locked_out, setup_req, fail_cnt,
                       disp_en ? disp : 16'hAAAA};

    function automatic logic [15:0] model_disp();
        logic [15:0] r;
        int n;
        r = 16'hAAAA;
        n = m_digits.size();
        for (int i = 0; i < n; i++) r[4*i +: 4] = m_digits[n-1-i];
        return r;
    endfunction

    function automatic int model_wait(input int fc);
        int w;
        if (fc <= 3) return 1;
        w = 10 * (fc - 3);
        return (w > 60) ? 60 : w;
    endfunction

    // 0 = master, 1 = enabled user slot, 2 = no match
    function automatic int classify(input logic [15:0] pin);
        if (pin == slot_pin[0]) return 0;
        for (int k = 1; k < 4; k++) if (slot_en[k] && pin == slot_pin[k]) return 1;
        return 2;
    endfunction

    task automatic push(input string name, input logic l, input logic b, input logic lo,
                        input logic sr, input logic [15:0] d, input int mn, input int mx);
        exp_t e;
        e.val = {l, b, lo, sr, m_fc, d};
        e.min_gap = mn;
        e.max_gap = mx;
        e.name = name;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            gap = gap + 1;
            if (cur !== mon_last) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_change got=%h last=%h", cur, mon_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (cur !== e.val) begin
                        failures++;
                        $display("FAIL %s got=%h expected=%h", e.name, cur, e.val);
                    end
                    checks++;
                    if (gap < e.min_gap || gap > e.max_gap) begin
                        failures++;
                        $display("FAIL %s_timing gap=%0d expected %0d..%0d",
                                 e.name, gap, e.min_gap, e.max_gap);
                    end
                end
                mon_last = cur;
                gap = 0;
            end
        end
    end

    task automatic press(input logic [3:0] code);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 key_code = code;
        key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_btn();
        @(posedge clk);
        #1 inside_btn = 1'b1;
        @(posedge clk);
        #1 inside_btn = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 setup_done = 1'b1;
        @(posedge clk);
        #1 setup_done = 1'b0;
    endtask

    task automatic wait_size(input int n, input int limit);
        int t = 0;
        while (exp_q.size() > n && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > n) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout pending=%0d required=%0d", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_drained(input int limit);
        wait_size(0, limit);
    endtask

    task automatic enter_pin(input logic [15:0] pin);
        logic [3:0] ign [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
        logic [3:0] d;
        int w;
        m_digits.delete();
        for (int i = 0; i < 4; i++) begin
            d = pin[15-4*i -: 4];
            m_digits.push_back(d);
            push("digit", 1'b0, 1'b0, 1'b0, 1'b0, model_disp(), 0, BIG);
            if (i == 3) begin
                case (classify(pin))
                    0: begin
                        m_fc = 4'd0;
                        push("setup", 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1, 5);
                    end
                    1: begin
                        m_fc = 4'd0;
                        push("unlock", 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 1, 5);
                        push("relock", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 42, 56);
                    end
                    default: begin
                        m_fc = (m_fc == 4'hF) ? 4'hF : m_fc + 4'd1;
                        w = model_wait(int'(m_fc));
                        push("lockout", 1'b0, 1'b0, 1'b1, 1'b0, 16'hBBBB, 1, 5);
                        push("lock_end", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA,
                             (w - 1) * 10, w * 10 + 3);
                    end
                endcase
            end
            if ($urandom_range(0, 3) == 0) press(ign[$urandom_range(0, 4)]);
            press(d);
        end
    endtask

    function automatic logic [15:0] wrong_pin();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
        if (classify(p) != 2) p[15:12] = 4'd9;
        if (classify(p) != 2) p = 16'h9876;
        return p;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int choice;
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        door_open = 1'b0;
        inside_btn = 1'b0;
        setup_done = 1'b0;
        pin_table = {slot_pin[3], slot_pin[2], slot_pin[1], slot_pin[0]};
        pin_en = slot_en;
        cfg_bip_en = 1'b1;
        cfg_bip_s = 7'd3;
        cfg_lock_s = 7'd5;
        cycles(3);

        checks++;
        if ({latch, buzzer, locked_out, setup_req, fail_cnt, disp, disp_en} !==
            {4'b1000, 4'd0, 16'hAAAA, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b_%h_%h_%b required=1000_0_aaaa_0",
                     {latch, buzzer, locked_out, setup_req}, fail_cnt, disp, disp_en);
        end

        mon_last = 24'h80AAAA;
        gap = 0;
        mon_en = 1'b1;
        push("locked", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 0, 4);
        rst = 1'b0;
        wait_drained(20);

        // User slot unlock, then auto-relock with the door shut.
        enter_pin(16'h0000);
        wait_drained(200);

        // Keys with the door open and a stray setup_done must do nothing.
        door_open = 1'b1;
        press(4'd5);
        cycles(2);
        door_open = 1'b0;
        pulse_done();
        cycles(3);

        // Free failures, including the disabled slot's PIN.
        enter_pin(16'h9999);
        wait_drained(100);
        enter_pin(16'h5678);
        wait_drained(100);
        enter_pin(wrong_pin());
        wait_drained(100);

        // First escalated lockout; keys meanwhile are ignored.
        enter_pin(16'h9999);
        wait_size(1, 20);
        for (int i = 0; i < 5; i++) press(4'($urandom_range(0, 15)));
        wait_drained(200);

        enter_pin(16'h1234);
        wait_drained(20);
        cycles($urandom_range(2, 6));
        push("setup_done", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 0, BIG);
        pulse_done();
        wait_drained(10);

        // Door held open by the inside button: alarm, then close and relock.
        door_open = 1'b1;
        cycles(2);
        push("btn_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 0, BIG);
        push("buzz_on", 1'b1, 1'b1, 1'b0, 1'b0, 16'hAAAA, 19, 34);
        pulse_btn();
        wait_drained(100);
        cycles($urandom_range(1, 20));
        push("buzz_off", 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 0, BIG);
        push("relock_door", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 39, 54);
        door_open = 1'b0;
        wait_drained(100);

        // Door reopening beats the button in the same cycle.
        push("btn_unlock2", 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 0, BIG);
        push("relock_race", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 45, 75);
        pulse_btn();
        cycles(6);
        door_open = 1'b1;
        inside_btn = 1'b1;
        cycles(1);
        door_open = 1'b0;
        inside_btn = 1'b0;
        wait_drained(120);

        // Partial entry abandoned by idling.
        m_digits.delete();
        m_digits.push_back(4'd1);
        push("digit", 1'b0, 1'b0, 1'b0, 1'b0, model_disp(), 0, BIG);
        press(4'd1);
        m_digits.push_back(4'd2);
        push("digit", 1'b0, 1'b0, 1'b0, 1'b0, model_disp(), 0, BIG);
        press(4'd2);
        push("timeout", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 39, 52);
        wait_drained(100);

        // Clear key mid-entry.
        m_digits.delete();
        m_digits.push_back(4'd5);
        push("digit", 1'b0, 1'b0, 1'b0, 1'b0, model_disp(), 0, BIG);
        press(4'd5);
        push("clear", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 1, 8);
        press(4'hE);
        wait_drained(20);

        for (int r = 0; r < 6; r++) begin
            choice = $urandom_range(0, 3);
            if (choice == 0) begin
                enter_pin(16'h0000);
                wait_drained(200);
            end else if (choice == 1) begin
                enter_pin(16'h1234);
                wait_drained(20);
                push("setup_done", 1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 0, BIG);
                pulse_done();
                wait_drained(10);
            end else begin
                enter_pin(wrong_pin());
                wait_drained(700);
            end
        end

        // Reset during a lockout clears the failure history.
        enter_pin(wrong_pin());
        wait_size(1, 20);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        cycles(1);
        checks++;
        if ({latch, locked_out, fail_cnt, disp} !== {1'b1, 1'b0, 4'd0, 16'hAAAA}) begin
            failures++;
            $display("FAIL reset_mid_lockout got=%b_%b_%h_%h required=1_0_0_aaaa",
                     latch, locked_out, fail_cnt, disp);
        end
        rst = 1'b0;
        cycles(3);
        checks++;
        if ({latch, locked_out, fail_cnt, disp} !== {1'b0, 1'b0, 4'd0, 16'hAAAA}) begin
            failures++;
            $display("FAIL after_reset_locked got=%b_%b_%h_%h required=0_0_0_aaaa",
                     latch, locked_out, fail_cnt, disp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
